// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back front end.
package wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 1 << REG_AW;

  localparam logic [REG_AW-1:0] X0 = '0;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small circular buffer of pending long-latency write-backs, exposing every
// slot and its occupancy so the owner can decode which registers are in flight.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = PW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  wb_req_t               push_req_i,
  input  logic                  pop_i,
  output wb_req_t               head_o,
  output logic [CW-1:0]         count_o,
  output logic [CW-1:0]         count_next_o,
  output logic                  full_o,
  output logic                  empty_o,
  output wb_req_t [DEPTH-1:0]   entry_o,
  output logic [DEPTH-1:0]      valid_o
);

  wb_req_t [DEPTH-1:0] mem_q;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                push_ok, pop_ok;
  logic [PW-1:0]       offset;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  assign wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
  assign rd_ptr_d = pop_ok  ? rd_ptr_q + PW'(1) : rd_ptr_q;
  assign count_d  = count_q + CW'(push_ok) - CW'(pop_ok);

  assign head_o       = mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;
  assign entry_o      = mem_q;

  always_comb begin
    valid_o = '0;
    offset  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset     = PW'(i) - rd_ptr_q;
      valid_o[i] = (CW'(offset) < count_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_req_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/wb_write_ctrl.sv
// Merges single-cycle pipeline results and buffered long-latency returns onto
// the register file's one write port, and reports pending destinations.
module wb_write_ctrl
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_valid,
  input  logic [REG_AW-1:0] pipe_rd,
  input  logic [XLEN-1:0]   pipe_data,
  input  logic              late_valid,
  output logic              late_ready,
  input  logic [REG_AW-1:0] late_rd,
  input  logic [XLEN-1:0]   late_data,
  output logic              rf_wen,
  output logic [REG_AW-1:0] rf_rd,
  output logic [XLEN-1:0]   rf_wdata,
  output logic [NREGS-1:0]  busy_mask,
  output logic              stall_req,
  output logic              waw_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  // Late-return handshake: a beat transfers on a cycle where late_valid and
  // late_ready are both high; late_ready depends only on occupancy, never on
  // a same-cycle pop, and the source holds its beat until it transfers.

  wb_req_t              push_req, head;
  wb_req_t [DEPTH-1:0]  entry;
  logic [DEPTH-1:0]     entry_valid;
  logic [CW-1:0]        count, count_next;
  logic                 fifo_full, fifo_empty;
  logic                 push, pop, pipe_take;
  logic [NREGS-1:0]     busy_w;

  logic                 rf_wen_q, rf_wen_d;
  logic [REG_AW-1:0]    rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]      rf_wdata_q, rf_wdata_d;
  logic                 stall_q, stall_d;
  logic                 waw_err_q, waw_err_d;

  assign push_req.rd   = late_rd;
  assign push_req.data = late_data;

  assign late_ready = !fifo_full;
  assign push       = late_valid && late_ready;
  // Writes to x0 never occupy the port, so they cannot block the drain.
  assign pipe_take  = pipe_valid && (pipe_rd != X0);
  assign pop        = !pipe_take && !fifo_empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .push_req_i   (push_req),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (count),
    .count_next_o (count_next),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .entry_o      (entry),
    .valid_o      (entry_valid)
  );

  always_comb begin
    busy_w = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) begin
        busy_w[entry[i].rd] = 1'b1;
      end
    end
    busy_w[0] = 1'b0;
  end

  always_comb begin
    rf_wen_d   = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    if (pipe_take) begin
      rf_wen_d   = 1'b1;
      rf_rd_d    = pipe_rd;
      rf_wdata_d = pipe_data;
    end else if (pop && (head.rd != X0)) begin
      rf_wen_d   = 1'b1;
      rf_rd_d    = head.rd;
      rf_wdata_d = head.data;
    end
    stall_d   = (count_next == CW'(DEPTH));
    waw_err_d = waw_err_q || (pipe_take && busy_w[pipe_rd]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_wen_q   <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      stall_q    <= 1'b0;
      waw_err_q  <= 1'b0;
    end else begin
      rf_wen_q   <= rf_wen_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      stall_q    <= stall_d;
      waw_err_q  <= waw_err_d;
    end
  end

  assign rf_wen    = rf_wen_q;
  assign rf_rd     = rf_rd_q;
  assign rf_wdata  = rf_wdata_q;
  assign busy_mask = busy_w;
  assign stall_req = stall_q;
  assign waw_err   = waw_err_q;

endmodule

// File: tb/tb_wb_write_ctrl.sv
// Directed bench for wb_write_ctrl: arbitration, FIFO fill/wrap, busy mask,
// WAW flag and mid-stream reset, with hand-computed expectations.
module tb_wb_write_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        late_valid;
  logic        late_ready;
  logic [4:0]  late_rd;
  logic [31:0] late_data;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [31:0] busy_mask;
  logic        stall_req;
  logic        waw_err;

  int errors = 0;
  int checks = 0;

  wb_write_ctrl #(.DEPTH(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .pipe_valid (pipe_valid),
    .pipe_rd    (pipe_rd),
    .pipe_data  (pipe_data),
    .late_valid (late_valid),
    .late_ready (late_ready),
    .late_rd    (late_rd),
    .late_data  (late_data),
    .rf_wen     (rf_wen),
    .rf_rd      (rf_rd),
    .rf_wdata   (rf_wdata),
    .busy_mask  (busy_mask),
    .stall_req  (stall_req),
    .waw_err    (waw_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pipe(input logic v, input logic [4:0] rd, input logic [31:0] d);
    pipe_valid = v;
    pipe_rd    = rd;
    pipe_data  = d;
  endtask

  task automatic late(input logic v, input logic [4:0] rd, input logic [31:0] d);
    late_valid = v;
    late_rd    = rd;
    late_data  = d;
  endtask

  task automatic chk_rf(input string tag, input logic wen, input logic [4:0] rd,
                        input logic [31:0] d);
    chk({tag, ".wen"}, 32'(rf_wen), 32'(wen));
    chk({tag, ".rd"}, 32'(rf_rd), 32'(rd));
    chk({tag, ".wdata"}, rf_wdata, d);
  endtask

  initial begin
    reset = 1'b1;
    pipe(1'b0, 5'd0, 32'h0);
    late(1'b0, 5'd0, 32'h0);
    tick();
    tick();

    // Reset state
    chk_rf("rst", 1'b0, 5'd0, 32'h0);
    chk("rst.busy", busy_mask, 32'h0);
    chk("rst.ready", 32'(late_ready), 32'h1);
    chk("rst.stall", 32'(stall_req), 32'h0);
    chk("rst.waw", 32'(waw_err), 32'h0);
    reset = 1'b0;
    tick();

    // Pipe only, then a discarded x0 pipe write
    pipe(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    chk_rf("pipe5", 1'b1, 5'd5, 32'hDEADBEEF);
    pipe(1'b1, 5'd0, 32'h00001234);
    tick();
    chk_rf("pipe0", 1'b0, 5'd5, 32'hDEADBEEF);
    pipe(1'b0, 5'd0, 32'h0);
    tick();
    chk("idle.wen", 32'(rf_wen), 32'h0);

    // Contention: late rd7 at N, pipe rd3 at N+1 and N+2
    late(1'b1, 5'd7, 32'h11);
    chk("cont.ready", 32'(late_ready), 32'h1);
    tick();
    chk("cont.n1.wen", 32'(rf_wen), 32'h0);
    chk("cont.n1.busy", busy_mask, 32'h0000_0080);
    late(1'b0, 5'd0, 32'h0);
    pipe(1'b1, 5'd3, 32'h22);
    tick();
    chk_rf("cont.n2", 1'b1, 5'd3, 32'h22);
    chk("cont.n2.busy", busy_mask, 32'h0000_0080);
    tick();
    chk_rf("cont.n3", 1'b1, 5'd3, 32'h22);
    chk("cont.n3.busy", busy_mask, 32'h0000_0080);
    pipe(1'b0, 5'd0, 32'h0);
    tick();
    chk_rf("cont.n4", 1'b1, 5'd7, 32'h11);
    chk("cont.n4.busy", busy_mask, 32'h0);
    chk("cont.waw", 32'(waw_err), 32'h0);
    tick();
    chk("cont.n5.wen", 32'(rf_wen), 32'h0);

    // Fill with duplicate rd1 entries while the pipe is busy
    late(1'b1, 5'd1, 32'hA1);
    pipe(1'b1, 5'd4, 32'h44);
    tick();
    chk_rf("fill.a", 1'b1, 5'd4, 32'h44);
    chk("fill.a.ready", 32'(late_ready), 32'h1);
    chk("fill.a.stall", 32'(stall_req), 32'h0);
    chk("fill.a.busy", busy_mask, 32'h2);
    late(1'b1, 5'd1, 32'hA2);
    pipe(1'b1, 5'd4, 32'h45);
    tick();
    chk_rf("fill.b", 1'b1, 5'd4, 32'h45);
    chk("fill.b.ready", 32'(late_ready), 32'h0);
    chk("fill.b.stall", 32'(stall_req), 32'h1);
    chk("fill.b.busy", busy_mask, 32'h2);
    // rd2 is offered while full and must be held, not dropped
    late(1'b1, 5'd2, 32'hB2);
    pipe(1'b0, 5'd0, 32'h0);
    tick();
    chk_rf("drain.1", 1'b1, 5'd1, 32'hA1);
    chk("drain.1.busy", busy_mask, 32'h2);
    chk("drain.1.ready", 32'(late_ready), 32'h1);
    chk("drain.1.stall", 32'(stall_req), 32'h0);
    tick();
    chk_rf("drain.2", 1'b1, 5'd1, 32'hA2);
    chk("drain.2.busy", busy_mask, 32'h4);
    chk("drain.2.ready", 32'(late_ready), 32'h1);
    late(1'b0, 5'd0, 32'h0);
    tick();
    chk_rf("drain.3", 1'b1, 5'd2, 32'hB2);
    chk("drain.3.busy", busy_mask, 32'h0);
    tick();
    chk("drain.4.wen", 32'(rf_wen), 32'h0);

    // Simultaneous push/pop at count=1, no fall-through on the first push
    late(1'b1, 5'd10, 32'hC0);
    tick();
    chk("pp.0.wen", 32'(rf_wen), 32'h0);
    chk("pp.0.busy", busy_mask, 32'h0000_0400);
    for (int k = 1; k <= 4; k++) begin
      late(1'b1, 5'(10 + k), 32'hC0 + 32'(k));
      chk("pp.ready", 32'(late_ready), 32'h1);
      tick();
      chk_rf("pp", 1'b1, 5'(10 + k - 1), 32'hC0 + 32'(k - 1));
      chk("pp.busy", busy_mask, 32'h1 << (10 + k));
      chk("pp.stall", 32'(stall_req), 32'h0);
    end
    late(1'b0, 5'd0, 32'h0);
    tick();
    chk_rf("pp.last", 1'b1, 5'd14, 32'hC4);
    chk("pp.last.busy", busy_mask, 32'h0);

    // WAW: late rd9 pending, then a pipe write to rd9
    late(1'b1, 5'd9, 32'h99);
    pipe(1'b1, 5'd6, 32'h66);
    tick();
    chk("waw.0", 32'(waw_err), 32'h0);
    chk("waw.0.busy", busy_mask, 32'h0000_0200);
    late(1'b0, 5'd0, 32'h0);
    pipe(1'b1, 5'd9, 32'h90);
    tick();
    chk("waw.1", 32'(waw_err), 32'h1);
    chk_rf("waw.1", 1'b1, 5'd9, 32'h90);
    pipe(1'b0, 5'd0, 32'h0);
    tick();
    chk_rf("waw.2", 1'b1, 5'd9, 32'h99);
    chk("waw.2", 32'(waw_err), 32'h1);
    chk("waw.2.busy", busy_mask, 32'h0);

    // x0 pipe request does not block the drain
    late(1'b1, 5'd8, 32'h88);
    tick();
    late(1'b0, 5'd0, 32'h0);
    pipe(1'b1, 5'd0, 32'h5555);
    tick();
    chk_rf("x0pipe", 1'b1, 5'd8, 32'h88);
    pipe(1'b0, 5'd0, 32'h0);

    // x0 late entry is accepted but pops without a write
    late(1'b1, 5'd0, 32'h77);
    tick();
    chk("x0late.busy", busy_mask, 32'h0);
    chk("x0late.ready", 32'(late_ready), 32'h1);
    late(1'b0, 5'd0, 32'h0);
    tick();
    chk_rf("x0late.pop", 1'b0, 5'd8, 32'h88);
    chk("x0late.waw", 32'(waw_err), 32'h1);

    // Reset mid-stream with a full FIFO
    late(1'b1, 5'd12, 32'hE1);
    pipe(1'b1, 5'd13, 32'h31);
    tick();
    late(1'b1, 5'd14, 32'hE2);
    pipe(1'b1, 5'd13, 32'h32);
    tick();
    chk("mid.busy", busy_mask, 32'h0000_5000);
    chk("mid.stall", 32'(stall_req), 32'h1);
    late(1'b0, 5'd0, 32'h0);
    pipe(1'b0, 5'd0, 32'h0);
    reset = 1'b1;
    #1;
    chk_rf("mrst", 1'b0, 5'd0, 32'h0);
    chk("mrst.busy", busy_mask, 32'h0);
    chk("mrst.ready", 32'(late_ready), 32'h1);
    chk("mrst.stall", 32'(stall_req), 32'h0);
    chk("mrst.waw", 32'(waw_err), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    chk("post.wen", 32'(rf_wen), 32'h0);
    chk("post.busy", busy_mask, 32'h0);
    tick();
    chk("post2.wen", 32'(rf_wen), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
